// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle unsigned MULTU/DIVU sequencer writing HI/LO.
// Each iteration borrows the shared datapath ALU (alu_req) for its 32-bit
// add/subtract; the ALU must answer combinationally in the same cycle.
// Optional feature macro: MDU_DIV_EN (restoring DIVU path and divide-by-zero
// handling). When undefined, DIVU completes immediately with HI = LO = 0.
module mdu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        alu_req,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mcand;
    logic        r_busy;
    logic        r_done;
    logic        r_alu_req;

    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic        w_carry;

`ifdef MDU_DIV_EN
    logic        r_op;
    logic [32:0] w_s;
    logic        w_ge;

    // Partial remainder shifted left by one with the next dividend bit; the
    // compare is 33 bits wide so a set top bit always allows the subtract.
    assign w_s  = {r_hi, r_lo[31]};
    assign w_ge = (w_s >= {1'b0, r_mcand});
`endif

    // Carry out of hi + mcand: an unsigned wrap makes the sum smaller than hi.
    assign w_carry = (alu_result < r_hi);

    // ALU operand/control drive; idle values when the ALU is not borrowed.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_alu_a    = '0;
        w_alu_b    = '0;
        if (r_alu_req) begin
`ifdef MDU_DIV_EN
            if (r_op) begin
                w_alu_ctrl = ALU_SUB;
                w_alu_a    = w_s[31:0];
                w_alu_b    = r_mcand;
            end else begin
                w_alu_a    = r_hi;
                w_alu_b    = r_mcand;
            end
`else
            w_alu_a = r_hi;
            w_alu_b = r_mcand;
`endif
        end
    end

    // Sequencer FSM: operand latch, 32 shift/add or shift/subtract steps, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_req <= 1'b0;
`ifdef MDU_DIV_EN
            r_op      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_count <= '0;
`ifdef MDU_DIV_EN
                        r_op    <= op;
                        if (op && (rt_val == 32'd0)) begin
                            // Divide by zero skips the iteration loop entirely.
                            r_hi    <= rs_val;
                            r_lo    <= 32'hFFFF_FFFF;
                            r_state <= S_DONE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (op) begin
                            r_hi      <= '0;
                            r_lo      <= rs_val;
                            r_mcand   <= rt_val;
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_alu_req <= 1'b1;
                        end else begin
                            r_hi      <= '0;
                            r_lo      <= rt_val;
                            r_mcand   <= rs_val;
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_alu_req <= 1'b1;
                        end
`else
                        if (op) begin
                            // Divide not built: finish at once with a zero result.
                            r_hi    <= '0;
                            r_lo    <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_hi      <= '0;
                            r_lo      <= rt_val;
                            r_mcand   <= rs_val;
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_alu_req <= 1'b1;
                        end
`endif
                    end
                end

                S_RUN: begin
`ifdef MDU_DIV_EN
                    if (r_op) begin
                        if (w_ge) begin
                            r_hi <= alu_result;
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_s[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else
`endif
                    if (r_lo[0]) begin
                        r_hi <= {w_carry, alu_result[31:1]};
                        r_lo <= {alu_result[0], r_lo[31:1]};
                    end else begin
                        r_hi <= {1'b0, r_hi[31:1]};
                        r_lo <= {r_hi[0], r_lo[31:1]};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state   <= S_DONE;
                        r_alu_req <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_alu_req <= 1'b0;
                end
            endcase
        end
    end

    assign alu_req  = r_alu_req;
    assign alu_ctrl = w_alu_ctrl;
    assign alu_a    = w_alu_a;
    assign alu_b    = w_alu_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: self-checking bench for mdu_sequencer with a stand-in
// combinational ALU and an arithmetic reference model (64-bit product,
// integer quotient/remainder). Expectations follow MDU_DIV_EN.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] rs_val, rt_val;
    logic        alu_req;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared datapath ALU stand-in: subtract for 0110, add otherwise.
    assign alu_result = (alu_ctrl == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .alu_req(alu_req), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Reference: expected latency (cycles from start to done) and HI/LO.
    function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        if (!o) begin
            p = 64'(a) * 64'(b);
            h = p[63:32];
            l = p[31:0];
            lat = 33;
        end else begin
`ifdef MDU_DIV_EN
            if (b == 0) begin
                h = a; l = 32'hFFFF_FFFF; lat = 1;
            end else begin
                l = a / b; h = a % b; lat = 33;
            end
`else
            h = 0; l = 0; lat = 1;
`endif
        end
    endfunction

    // Runs one operation starting at the current negedge; observes only.
    // inj_kind: 0 none, 1 extra start (3x3) in cycle inj_cyc, 2 reset in cycle inj_cyc.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, input int inj_kind, input int limit,
                         output int done_cyc, output int done_cnt,
                         output logic [31:0] h, output logic [31:0] l,
                         output int req_cnt, output int req_err, output int ctrl_err,
                         output int idle_err, output logic busy_at_done, output logic end_busy,
                         output logic post_busy, output logic [31:0] post_hi, output logic [31:0] post_lo);
        logic [3:0] exp_ctrl;
        exp_ctrl = o ? 4'b0110 : 4'b0010;
        done_cyc = -1; done_cnt = 0; h = 'x; l = 'x;
        req_cnt = 0; req_err = 0; ctrl_err = 0; idle_err = 0;
        busy_at_done = 1'bx; end_busy = 1'bx;
        post_busy = 1'bx; post_hi = 'x; post_lo = 'x;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (alu_req === 1'b1) begin
                req_cnt++;
                if (c > 32) req_err++;
                if (alu_ctrl !== exp_ctrl) ctrl_err++;
            end else if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'b0010) begin
                idle_err++;
            end
            if (c == inj_cyc + 1) begin
                post_busy = busy; post_hi = hi; post_lo = lo;
                start = 1'b0; reset = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; h = hi; l = lo; busy_at_done = busy;
                end
            end
            if (c == inj_cyc) begin
                if (inj_kind == 1) begin
                    start = 1'b1; op = 1'b0; rs_val = 32'd3; rt_val = 32'd3;
                end else if (inj_kind == 2) begin
                    reset = 1'b1;
                end
            end
            if (done_cyc > 0 && c == done_cyc + 1) begin
                end_busy = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 1'b0; rs_val = 32'd7; rt_val = 32'd6;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", alu_req); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL reset_ab got=%h/%h want=0/0", alu_a, alu_b); end
        total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("FAIL reset_ctrl got=%b want=0010", alu_ctrl); end
        // start held alongside reset must have been discarded
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_wins_busy got=%b want=0", busy); end
    endtask

    task automatic test_mult_directed();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        do_op(1'b0, 32'd7, 32'd6, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== 33) begin bad++; $display("FAIL mul7x6_latency got=%0d want=33", dc); end
        total++; if (h !== 32'd0 || l !== 32'd42) begin bad++; $display("FAIL mul7x6_result got=%h_%h want=0_2a", h, l); end
        total++; if (rc !== 32 || re !== 0) begin bad++; $display("FAIL mul7x6_req got=%0d late=%0d want=32/0", rc, re); end
        total++; if (ce !== 0 || ie !== 0) begin bad++; $display("FAIL mul7x6_alu_drive got=%0d/%0d want=0/0", ce, ie); end
        total++; if (bd !== 1'b1 || eb !== 1'b0) begin bad++; $display("FAIL mul7x6_busy got=%b/%b want=1/0", bd, eb); end
        // back-to-back: accepted in the first IDLE cycle after done
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== 33) begin bad++; $display("FAIL mulmax_latency got=%0d want=33", dc); end
        total++; if (h !== 32'hFFFF_FFFE || l !== 32'h1) begin bad++; $display("FAIL mulmax_result got=%h_%h want=fffffffe_00000001", h, l); end
    endtask

    task automatic test_div_directed();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        int elat; logic [31:0] eh1, el1, eh2, el2;
`ifdef MDU_DIV_EN
        elat = 33; eh1 = 32'd2; el1 = 32'd14; eh2 = 32'h7FFF_FFFF; el2 = 32'd1;
`else
        elat = 1; eh1 = 0; el1 = 0; eh2 = 0; el2 = 0;
`endif
        do_op(1'b1, 32'd100, 32'd7, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== elat) begin bad++; $display("FAIL div100_7_latency got=%0d want=%0d", dc, elat); end
        total++; if (h !== eh1 || l !== el1) begin bad++; $display("FAIL div100_7_result got=%h_%h want=%h_%h", h, l, eh1, el1); end
        total++; if (ce !== 0 || ie !== 0 || rc !== (elat == 33 ? 32 : 0)) begin bad++; $display("FAIL div100_7_alu got=%0d/%0d/%0d want=0/0/%0d", ce, ie, rc, (elat == 33 ? 32 : 0)); end
        do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (h !== eh2 || l !== el2) begin bad++; $display("FAIL div_33bit_result got=%h_%h want=%h_%h", h, l, eh2, el2); end
    endtask

    task automatic test_div_zero();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        logic [31:0] eh, el;
`ifdef MDU_DIV_EN
        eh = 32'd5; el = 32'hFFFF_FFFF;
`else
        eh = 32'd0; el = 32'd0;
`endif
        do_op(1'b1, 32'd5, 32'd0, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", dc); end
        total++; if (h !== eh || l !== el) begin bad++; $display("FAIL divzero_result got=%h_%h want=%h_%h", h, l, eh, el); end
        total++; if (rc !== 0 || bd !== 1'b1 || eb !== 1'b0) begin bad++; $display("FAIL divzero_ctrl got=req%0d busy%b/%b want=req0 busy1/0", rc, bd, eb); end
    endtask

    task automatic test_ignored_start();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        do_op(1'b0, 32'd7, 32'd6, 10, 1, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== 33 || dn !== 1) begin bad++; $display("FAIL ignored_start_done got=cyc%0d cnt%0d want=cyc33 cnt1", dc, dn); end
        total++; if (h !== 32'd0 || l !== 32'd42) begin bad++; $display("FAIL ignored_start_result got=%h_%h want=0_2a", h, l); end
    endtask

    task automatic test_reset_mid_run();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        do_op(1'b0, 32'd7, 32'd6, 15, 2, 40, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dn !== 0) begin bad++; $display("FAIL midreset_done got=%0d want=0", dn); end
        total++; if (pb !== 1'b0 || ph !== 32'd0 || pl !== 32'd0) begin bad++; $display("FAIL midreset_state got=busy%b %h_%h want=busy0 0_0", pb, ph, pl); end
        total++; if (rc !== 15 || ie !== 0) begin bad++; $display("FAIL midreset_req got=%0d idle_err=%0d want=15/0", rc, ie); end
        do_op(1'b0, 32'd2, 32'd2, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
        total++; if (dc !== 33 || h !== 32'd0 || l !== 32'd4) begin bad++; $display("FAIL after_reset_2x2 got=cyc%0d %h_%h want=cyc33 0_4", dc, h, l); end
    endtask

    task automatic test_random();
        int dc, dn, rc, re, ce, ie; logic bd, eb, pb; logic [31:0] h, l, ph, pl;
        int elat; logic [31:0] eh, el, a, b; logic o;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 255);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = a >> $urandom_range(0, 31);
            model(o, a, b, elat, eh, el);
            do_op(o, a, b, -5, 0, 60, dc, dn, h, l, rc, re, ce, ie, bd, eb, pb, ph, pl);
            total++; if (dc !== elat || h !== eh || l !== el) begin
                bad++; $display("FAIL rand%0d op=%0d a=%h b=%h got=cyc%0d %h_%h want=cyc%0d %h_%h", i, o, a, b, dc, h, l, elat, eh, el);
            end
            total++; if (ce !== 0 || ie !== 0 || re !== 0 || rc !== (elat == 33 ? 32 : 0)) begin
                bad++; $display("FAIL rand%0d_alu got=ctrl%0d idle%0d late%0d req%0d want=0/0/0/%0d", i, ce, ie, re, rc, (elat == 33 ? 32 : 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
